// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame length, host commands.
// Used by ps2_cmd_transmitter and the keyboard receive path.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SHIFT,
      ACK,
      WAIT_IDLE
   } state_t;

   localparam int FRAME_LEN = 11;

   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;

   // Bits shifted after the start bit: d0..d7, odd parity, stop.
   function automatic logic [9:0] tx_frame(input logic [7:0] d);
      return {1'b1, ~^d, d};
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer with a falling-edge detector for one PS/2 pin.
// Flops reset high so an idle bus never reports a spurious edge.
module ps2_sync_edge (
   input  logic clk,
   input  logic resetn,
   input  logic pin,
   output logic sync,
   output logic fe
);

   logic meta;
   logic prev;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= pin;
         sync <= meta;
         prev <= sync;
      end
   end

   assign fe = prev & ~sync;

endmodule

// File: rtl/ps2_cmd_transmitter.sv
// Host-to-device PS/2 command transmitter driving open-drain enables.
// Define PS2_TX_TIMEOUT_EN to build the clock-release-to-ack watchdog.
module ps2_cmd_transmitter #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int RTS_CYCLES     = 50,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   output logic       cmd_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);

   import ps2_pkg::*;

   localparam logic [31:0] INH_LAST = 32'(INHIBIT_CYCLES - 1);
   localparam logic [31:0] RTS_LAST = 32'(RTS_CYCLES - 1);
   localparam logic [3:0]  LAST_BIT = 4'(FRAME_LEN - 2);

   state_t      state;
   logic [9:0]  frame;
   logic [3:0]  bit_cnt;
   logic [31:0] phase_cnt;

   logic sync_clk;
   logic clk_fe;
   logic sync_dat;
   logic unused_dat_fe;
   logic wd_exp;

   ps2_sync_edge u_clk_sync (
      .clk    (CLOCK_50),
      .resetn (resetn),
      .pin    (ps2_clk_in),
      .sync   (sync_clk),
      .fe     (clk_fe)
   );

   ps2_sync_edge u_dat_sync (
      .clk    (CLOCK_50),
      .resetn (resetn),
      .pin    (ps2_dat_in),
      .sync   (sync_dat),
      .fe     (unused_dat_fe)
   );

`ifdef PS2_TX_TIMEOUT_EN
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

   logic [31:0] wd_cnt;
   logic        wd_run;

   assign wd_run = (state == SHIFT) || (state == ACK) ||
                   (state == WAIT_IDLE);
   assign wd_exp = wd_run && (wd_cnt == TO_LAST);

   // Restarted while RTS holds the bus, so counting begins at clock release.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         wd_cnt <= '0;
      end else if (state == RTS) begin
         wd_cnt <= '0;
      end else if (wd_run) begin
         wd_cnt <= wd_cnt + 32'd1;
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign wd_exp = 1'b0;
`endif

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         frame      <= '0;
         bit_cnt    <= '0;
         phase_cnt  <= '0;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
         done       <= 1'b0;
         ack_err    <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (wd_exp) begin
            // Expiry outranks a device clock edge in the same cycle.
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            timeout    <= 1'b1;
            ack_err    <= 1'b1;
            done       <= 1'b1;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (cmd_valid) begin
                     frame      <= tx_frame(cmd_data);
                     ack_err    <= 1'b0;
                     timeout    <= 1'b0;
                     ps2_clk_oe <= 1'b1;
                     cmd_ready  <= 1'b0;
                     busy       <= 1'b1;
                     phase_cnt  <= '0;
                     state      <= INHIBIT;
                  end
               end
               INHIBIT: begin
                  if (phase_cnt == INH_LAST) begin
                     phase_cnt  <= '0;
                     ps2_dat_oe <= 1'b1;
                     state      <= RTS;
                  end else begin
                     phase_cnt <= phase_cnt + 32'd1;
                  end
               end
               RTS: begin
                  if (phase_cnt == RTS_LAST) begin
                     phase_cnt  <= '0;
                     ps2_clk_oe <= 1'b0;
                     bit_cnt    <= '0;
                     state      <= SHIFT;
                  end else begin
                     phase_cnt <= phase_cnt + 32'd1;
                  end
               end
               SHIFT: begin
                  if (clk_fe) begin
                     ps2_dat_oe <= ~frame[bit_cnt];
                     bit_cnt    <= bit_cnt + 4'd1;
                     if (bit_cnt == LAST_BIT) begin
                        state <= ACK;
                     end
                  end
               end
               ACK: begin
                  if (clk_fe) begin
                     ack_err <= sync_dat;
                     state   <= WAIT_IDLE;
                  end
               end
               WAIT_IDLE: begin
                  if (sync_clk && sync_dat) begin
                     ps2_dat_oe <= 1'b0;
                     done       <= 1'b1;
                     cmd_ready  <= 1'b1;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_cmd_transmitter.sv
// Scoreboard bench for ps2_cmd_transmitter with a behavioural PS/2 device.
// Watchdog scenario is exercised only when PS2_TX_TIMEOUT_EN is defined.
module tb_ps2_cmd_transmitter;

   import ps2_pkg::*;

   localparam int INH     = 20;
   localparam int RTSC    = 6;
   localparam int TO      = 600;
   localparam int HALF    = 10;
   localparam int DEV_PER = 2 * HALF + 2;

   typedef struct {
      logic [7:0] data;
      logic       ack_err;
      logic       timeout;
      logic       chk_frame;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready;
   logic       ps2_clk_oe;
   logic       ps2_dat_oe;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic       timeout;
   logic       dev_clk = 1'b1;
   logic       dev_dat = 1'b1;
   logic       ps2_clk;
   logic       ps2_dat;

   exp_t        sb[$];
   logic [10:0] obs_frame;
   int          checks = 0;
   int          errors = 0;

   assign ps2_clk = ~ps2_clk_oe & dev_clk;
   assign ps2_dat = ~ps2_dat_oe & dev_dat;

   always #10 clk = ~clk;

   ps2_cmd_transmitter #(
      .INHIBIT_CYCLES (INH),
      .RTS_CYCLES     (RTSC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .CLOCK_50   (clk),
      .resetn     (resetn),
      .cmd_valid  (cmd_valid),
      .cmd_data   (cmd_data),
      .cmd_ready  (cmd_ready),
      .ps2_clk_in (ps2_clk),
      .ps2_dat_in (ps2_dat),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe),
      .busy       (busy),
      .done       (done),
      .ack_err    (ack_err),
      .timeout    (timeout)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every done pulse must match the oldest request.
   always @(negedge clk) begin
      if (resetn && done) begin
         exp_t e;
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("ack_err", 32'(ack_err), 32'(e.ack_err));
            check("timeout", 32'(timeout), 32'(e.timeout));
            check("oe_at_done", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
            if (e.chk_frame) begin
               check("frame", 32'(obs_frame),
                     32'({1'b1, ~^e.data, e.data, 1'b0}));
            end
         end
      end
   end

   task automatic send_cmd(input logic [7:0] d, input bit spam,
                           input bit exp_ae, input bit exp_to,
                           input bit chk);
      int n;
      @(negedge clk);
      check("ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_data  = d;
      sb.push_back('{d, exp_ae, exp_to, chk});
      @(negedge clk);
      if (spam) cmd_data = CMD_ENABLE;
      else cmd_valid = 1'b0;
      check("clk_oe_accept", 32'(ps2_clk_oe), 32'd1);
      check("dat_oe_accept", 32'(ps2_dat_oe), 32'd0);
      check("busy_accept", 32'(busy), 32'd1);
      check("ready_accept", 32'(cmd_ready), 32'd0);
      check("status_clear", 32'({ack_err, timeout}), 32'd0);
      n = 1;
      while (!ps2_dat_oe && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("inhibit_len", 32'(n), 32'(INH + 1));
      while (ps2_clk_oe && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("rts_end", 32'(n), 32'(INH + RTSC + 1));
      cmd_valid = 1'b0;
   endtask

   task automatic device(input int nclk, input bit do_ack);
      obs_frame    = '1;
      obs_frame[0] = ps2_dat;
      for (int i = 1; i <= nclk; i++) begin
         repeat (HALF) @(negedge clk);
         if (i == FRAME_LEN && do_ack) dev_dat = 1'b0;
         repeat (2) @(negedge clk);
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b1;
         if (i < FRAME_LEN) obs_frame[i] = ps2_dat;
         if (i == FRAME_LEN) dev_dat = 1'b1;
      end
   endtask

   task automatic wait_done(input int limit, output int n);
      n = 0;
      while (!done && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 32'(done), 32'd1);
      if (done) begin
         @(negedge clk);
         check("done_width", 32'(done), 32'd0);
         check("ready_after", 32'(cmd_ready), 32'd1);
         check("busy_after", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      check("rst_flags", 32'({busy, done, ack_err, timeout}), 32'd0);
      resetn = 1'b1;
      repeat (3) @(negedge clk);

      send_cmd(CMD_SET_LED, 1'b0, 1'b0, 1'b0, 1'b1);
      device(11, 1'b1);
      wait_done(200, n);

      send_cmd(CMD_ENABLE, 1'b0, 1'b0, 1'b0, 1'b1);
      device(11, 1'b1);
      wait_done(200, n);

      send_cmd(CMD_RESET, 1'b0, 1'b1, 1'b0, 1'b1);
      device(11, 1'b0);
      wait_done(200, n);
      repeat (5) @(negedge clk);
      check("ack_err_hold", 32'(ack_err), 32'd1);

      send_cmd(CMD_SET_LED, 1'b1, 1'b0, 1'b0, 1'b1);
      device(11, 1'b1);
      wait_done(200, n);
      repeat (300) @(negedge clk);
      check("single_frame", 32'(sb.size()), 32'd0);

      send_cmd(CMD_RESET, 1'b0, 1'b0, 1'b0, 1'b1);
      device(3, 1'b0);
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (4) @(negedge clk);
      check("shift_busy", 32'(busy), 32'd1);
      check("shift_d3", 32'(ps2_dat_oe), 32'd0);
      #1 resetn = 1'b0;
      #1;
      check("rst_async_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
      check("rst_async_ready", 32'(cmd_ready), 32'd1);
      sb.delete();
      dev_clk = 1'b1;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (300) @(negedge clk);
      send_cmd(CMD_RESET, 1'b0, 1'b0, 1'b0, 1'b1);
      device(11, 1'b1);
      wait_done(200, n);

`ifdef PS2_TX_TIMEOUT_EN
      send_cmd(CMD_ENABLE, 1'b0, 1'b1, 1'b1, 1'b0);
      device(5, 1'b0);
      wait_done(TO + 100, n);
      check("timeout_len", 32'(n + 5 * DEV_PER), 32'(TO));
`endif

      repeat (20) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
